// File: rtl/lsu_access_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_access_ctrl
//
// Load/store access controller in front of a 256-byte data memory with a
// combinational read and a falling-edge write. Accepts one request at a time
// over a valid/ready handshake. It computes the 8-bit effective address and
// performs exactly one memory access. It then returns load data, or store
// completion, over a valid/ready response handshake.
//
// Optional feature macro: LSU_POSTINC_EN
//   When defined, this adds a post-increment addressing mode.
//   The request selects it with req_postinc.
//   The updated base is returned on resp_base for base-register writeback.
//
// Parameters:
//   WAIT_STATES  extra ACCESS cycles before completion (0..15)
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid / req_ready    request handshake
//   req_store                1 = store, 0 = load
//   req_base, req_offset     address operands (added modulo 256)
//   req_wdata                store data
//   req_postinc              (LSU_POSTINC_EN) access at base, write back base+offset
//   resp_valid / resp_ready  response handshake
//   resp_rdata               load data (0 for stores)
//   resp_ea                  effective address used
//   resp_base                (LSU_POSTINC_EN) base-register writeback value
//   mem_ea, mem_result       memory address / write data
//   mem_en                   memory write enable
//   mem_data                 memory combinational read data
// -----------------------------------------------------------------------------
module lsu_access_ctrl #(
    parameter int WAIT_STATES = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_store,
    input  logic [7:0] req_base,
    input  logic [7:0] req_offset,
    input  logic [7:0] req_wdata,
`ifdef LSU_POSTINC_EN
    input  logic       req_postinc,
`endif
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic [7:0] resp_rdata,
    output logic [7:0] resp_ea,
`ifdef LSU_POSTINC_EN
    output logic [7:0] resp_base,
`endif
    output logic [7:0] mem_ea,
    output logic [7:0] mem_result,
    output logic       mem_en,
    input  logic [7:0] mem_data
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t     state_reg;
    logic       op_reg;
    logic [7:0] ea_reg;
    logic [7:0] wdata_reg;
    logic [7:0] rdata_reg;
    logic [3:0] cnt_reg;
    logic       req_ready_reg;
    logic       resp_valid_reg;

    // The carry out of the 8-bit add is dropped, so addresses wrap modulo 256.
    logic [7:0] ea_sum;
    logic [7:0] ea_next;

`ifdef LSU_POSTINC_EN
    logic [7:0] base_reg;
    logic [7:0] base_next;

    always_comb begin
        ea_sum = req_base + req_offset;
        // Post-increment: the access uses the unmodified base.
        // The sum is returned as the new base value.
        ea_next   = req_postinc ? req_base : ea_sum;
        base_next = req_postinc ? ea_sum   : req_base;
    end

    assign resp_base = base_reg;
`else
    always_comb begin
        ea_sum  = req_base + req_offset;
        ea_next = ea_sum;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            op_reg         <= 1'b0;
            ea_reg         <= 8'h00;
            wdata_reg      <= 8'h00;
            rdata_reg      <= 8'h00;
            cnt_reg        <= 4'd0;
            req_ready_reg  <= 1'b1;
            resp_valid_reg <= 1'b0;
`ifdef LSU_POSTINC_EN
            base_reg       <= 8'h00;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_reg        <= req_store;
                        ea_reg        <= ea_next;
                        wdata_reg     <= req_wdata;
                        cnt_reg       <= 4'(WAIT_STATES);
`ifdef LSU_POSTINC_EN
                        base_reg      <= base_next;
`endif
                        req_ready_reg <= 1'b0;
                        state_reg     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else begin
                        // The final ACCESS cycle captures load data.
                        // For a store, the write lands on this cycle's falling edge.
                        rdata_reg      <= op_reg ? 8'h00 : mem_data;
                        resp_valid_reg <= 1'b1;
                        state_reg      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid_reg <= 1'b0;
                        req_ready_reg  <= 1'b1;
                        state_reg      <= ST_IDLE;
                    end
                end
                default: begin
                    req_ready_reg  <= 1'b1;
                    resp_valid_reg <= 1'b0;
                    state_reg      <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_rdata = rdata_reg;
    assign resp_ea    = ea_reg;

    // The address and write data come straight from the latched request.
    // They change only on the edge that enters ACCESS.
    // This keeps them stable across the falling-edge write.
    assign mem_ea     = ea_reg;
    assign mem_result = wdata_reg;

    // Decoded from registered state only, so the memory never sees a glitch.
    // This gives exactly one write-enable cycle per store.
    assign mem_en = (state_reg == ST_ACCESS) && op_reg && (cnt_reg == 4'd0);

endmodule

// File: tb/tb_lsu_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_access_ctrl
//
// Directed bench for lsu_access_ctrl.
// Instance 0 runs with WAIT_STATES=0; instance 1 runs with WAIT_STATES=3.
// Each instance has its own 256-byte memory with a combinational read.
// The memory writes on the falling edge and is cleared by rst.
// Covers the post-increment mode when LSU_POSTINC_EN is defined.
// -----------------------------------------------------------------------------
module tb_lsu_access_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       req_valid  [2];
    logic       req_ready  [2];
    logic       req_store  [2];
    logic [7:0] req_base   [2];
    logic [7:0] req_offset [2];
    logic [7:0] req_wdata  [2];
    logic       req_postinc[2];
    logic       resp_valid [2];
    logic       resp_ready [2];
    logic [7:0] resp_rdata [2];
    logic [7:0] resp_ea    [2];
    logic [7:0] resp_base  [2];
    logic [7:0] mem_ea     [2];
    logic [7:0] mem_result [2];
    logic       mem_en     [2];
    logic [7:0] mem_data   [2];

    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    lsu_access_ctrl #(.WAIT_STATES(0)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid[0]),
        .req_ready  (req_ready[0]),
        .req_store  (req_store[0]),
        .req_base   (req_base[0]),
        .req_offset (req_offset[0]),
        .req_wdata  (req_wdata[0]),
`ifdef LSU_POSTINC_EN
        .req_postinc(req_postinc[0]),
`endif
        .resp_valid (resp_valid[0]),
        .resp_ready (resp_ready[0]),
        .resp_rdata (resp_rdata[0]),
        .resp_ea    (resp_ea[0]),
`ifdef LSU_POSTINC_EN
        .resp_base  (resp_base[0]),
`endif
        .mem_ea     (mem_ea[0]),
        .mem_result (mem_result[0]),
        .mem_en     (mem_en[0]),
        .mem_data   (mem_data[0])
    );

    lsu_access_ctrl #(.WAIT_STATES(3)) dut3 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid[1]),
        .req_ready  (req_ready[1]),
        .req_store  (req_store[1]),
        .req_base   (req_base[1]),
        .req_offset (req_offset[1]),
        .req_wdata  (req_wdata[1]),
`ifdef LSU_POSTINC_EN
        .req_postinc(req_postinc[1]),
`endif
        .resp_valid (resp_valid[1]),
        .resp_ready (resp_ready[1]),
        .resp_rdata (resp_rdata[1]),
        .resp_ea    (resp_ea[1]),
`ifdef LSU_POSTINC_EN
        .resp_base  (resp_base[1]),
`endif
        .mem_ea     (mem_ea[1]),
        .mem_result (mem_result[1]),
        .mem_en     (mem_en[1]),
        .mem_data   (mem_data[1])
    );

`ifndef LSU_POSTINC_EN
    assign resp_base[0] = 8'h00;
    assign resp_base[1] = 8'h00;
`endif

    // Memory models: combinational read, falling-edge write, cleared by rst.
    assign mem_data[0] = mem0[mem_ea[0]];
    assign mem_data[1] = mem1[mem_ea[1]];

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) begin
                mem0[i] = 8'h00;
                mem1[i] = 8'h00;
            end
        end else begin
            if (mem_en[0]) mem0[mem_ea[0]] = mem_result[0];
            if (mem_en[1]) mem1[mem_ea[1]] = mem_result[1];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    // Offers one request, checks that it is acceptable, and takes the
    // acceptance edge. On return the instance is in its first ACCESS cycle.
    task automatic do_req(input int idx, input logic st, input logic [7:0] base,
                          input logic [7:0] off, input logic [7:0] wd, input logic pinc);
        req_valid[idx]   = 1'b1;
        req_store[idx]   = st;
        req_base[idx]    = base;
        req_offset[idx]  = off;
        req_wdata[idx]   = wd;
        req_postinc[idx] = pinc;
        check("req_ready_before_accept", 8'(req_ready[idx]), 8'h01);
        tick();
        req_valid[idx] = 1'b0;
        $display("[TB] inst%0d %s base=0x%02h off=0x%02h wdata=0x%02h postinc=%0d accepted",
                 idx, st ? "store" : "load", base, off, wd, pinc);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            req_valid[i]   = 1'b0;
            req_store[i]   = 1'b0;
            req_base[i]    = 8'h00;
            req_offset[i]  = 8'h00;
            req_wdata[i]   = 8'h00;
            req_postinc[i] = 1'b0;
            resp_ready[i]  = 1'b1;
        end

        // ---- Reset state ----
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_req_ready",  8'(req_ready[0]),  8'h01);
        check("rst_resp_valid", 8'(resp_valid[0]), 8'h00);
        check("rst_resp_rdata", resp_rdata[0],     8'h00);
        check("rst_resp_ea",    resp_ea[0],        8'h00);
        check("rst_mem_ea",     mem_ea[0],         8'h00);
        check("rst_mem_result", mem_result[0],     8'h00);
        check("rst_mem_en",     8'(mem_en[0]),     8'h00);
        check("rst_req_ready3", 8'(req_ready[1]),  8'h01);

        // ---- Store 0x10+0x05 <- 0xA5, W=0 ----
        do_req(0, 1'b1, 8'h10, 8'h05, 8'hA5, 1'b0);
        check("st_mem_en",       8'(mem_en[0]),     8'h01);
        check("st_mem_ea",       mem_ea[0],         8'h15);
        check("st_mem_result",   mem_result[0],     8'hA5);
        check("st_req_ready",    8'(req_ready[0]),  8'h00);
        check("st_resp_valid0",  8'(resp_valid[0]), 8'h00);
        tick();
        check("st_mem_en_off",   8'(mem_en[0]),     8'h00);
        check("st_resp_valid",   8'(resp_valid[0]), 8'h01);
        check("st_resp_ea",      resp_ea[0],        8'h15);
        check("st_resp_rdata",   resp_rdata[0],     8'h00);
        tick();
        check("st_idle_ready",   8'(req_ready[0]),  8'h01);
        check("st_idle_rvalid",  8'(resp_valid[0]), 8'h00);
        check("st_mem_written",  mem0[8'h15],       8'hA5);
        $display("[TB] inst0 store 0x15 done");

        // ---- Load 0x10+0x05, W=0 ----
        do_req(0, 1'b0, 8'h10, 8'h05, 8'h00, 1'b0);
        check("ld_mem_en",       8'(mem_en[0]),     8'h00);
        check("ld_resp_valid0",  8'(resp_valid[0]), 8'h00);
        tick();
        check("ld_resp_valid",   8'(resp_valid[0]), 8'h01);
        check("ld_resp_rdata",   resp_rdata[0],     8'hA5);
        check("ld_resp_ea",      resp_ea[0],        8'h15);
        tick();
        $display("[TB] inst0 load 0x15 done rdata=0x%02h", resp_rdata[0]);

        // ---- Address wrap: 0xF0+0x20 -> 0x10 ----
        do_req(0, 1'b1, 8'hF0, 8'h20, 8'h3C, 1'b0);
        check("wrap_mem_ea",     mem_ea[0],         8'h10);
        check("wrap_mem_en",     8'(mem_en[0]),     8'h01);
        tick();
        check("wrap_resp_ea",    resp_ea[0],        8'h10);
        tick();
        check("wrap_mem_written", mem0[8'h10],      8'h3C);
        $display("[TB] inst0 wrap store done");

        // ---- Backpressure on the response ----
        resp_ready[0] = 1'b0;
        do_req(0, 1'b0, 8'h15, 8'h00, 8'h00, 1'b0);
        tick();
        // The second request is offered while the response is stalled.
        req_valid[0]  = 1'b1;
        req_store[0]  = 1'b0;
        req_base[0]   = 8'h08;
        req_offset[0] = 8'h08;
        for (int k = 0; k < 5; k++) begin
            check("bp_resp_valid", 8'(resp_valid[0]), 8'h01);
            check("bp_resp_rdata", resp_rdata[0],     8'hA5);
            check("bp_resp_ea",    resp_ea[0],        8'h15);
            check("bp_req_ready",  8'(req_ready[0]),  8'h00);
            tick();
        end
        resp_ready[0] = 1'b1;
        tick();
        check("bp_after_hs_rvalid", 8'(resp_valid[0]), 8'h00);
        check("bp_after_hs_ready",  8'(req_ready[0]),  8'h01);
        tick();
        req_valid[0] = 1'b0;
        check("bp_second_accepted", 8'(req_ready[0]), 8'h00);
        check("bp_second_mem_ea",   mem_ea[0],        8'h10);
        tick();
        check("bp_second_rdata",    resp_rdata[0],    8'h3C);
        tick();
        $display("[TB] inst0 backpressure sequence done");

        // ---- Wait states, W=3: store then load ----
        do_req(1, 1'b1, 8'h40, 8'h00, 8'h5A, 1'b0);
        for (int k = 0; k < 4; k++) begin
            check("w3_st_mem_en",     8'(mem_en[1]),     8'(k == 3));
            check("w3_st_resp_valid", 8'(resp_valid[1]), 8'h00);
            tick();
        end
        check("w3_st_resp_valid1", 8'(resp_valid[1]), 8'h01);
        tick();
        check("w3_st_mem_written", mem1[8'h40], 8'h5A);
        $display("[TB] inst1 W=3 store done");

        do_req(1, 1'b0, 8'h40, 8'h00, 8'h00, 1'b0);
        for (int k = 0; k < 4; k++) begin
            check("w3_ld_resp_valid", 8'(resp_valid[1]), 8'h00);
            check("w3_ld_mem_en",     8'(mem_en[1]),     8'h00);
            tick();
        end
        check("w3_ld_resp_valid1", 8'(resp_valid[1]), 8'h01);
        check("w3_ld_resp_rdata",  resp_rdata[1],     8'h5A);
        tick();
        $display("[TB] inst1 W=3 load done");

        // ---- Reset during ACCESS of a load ----
        do_req(1, 1'b0, 8'h40, 8'h02, 8'h00, 1'b0);
        check("rmid_mem_ea_access", mem_ea[1], 8'h42);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rmid_req_ready",  8'(req_ready[1]),  8'h01);
        check("rmid_resp_valid", 8'(resp_valid[1]), 8'h00);
        check("rmid_resp_rdata", resp_rdata[1],     8'h00);
        check("rmid_resp_ea",    resp_ea[1],        8'h00);
        check("rmid_mem_ea",     mem_ea[1],         8'h00);
        check("rmid_mem_result", mem_result[1],     8'h00);
        check("rmid_mem_en",     8'(mem_en[1]),     8'h00);
        for (int k = 0; k < 6; k++) tick();
        check("rmid_no_resp",    8'(resp_valid[1]), 8'h00);
        $display("[TB] inst1 reset mid-op done");

`ifdef LSU_POSTINC_EN
        // ---- Post-increment load ----
        do_req(0, 1'b1, 8'h20, 8'h00, 8'h77, 1'b0);
        tick();
        check("pi_store_base",  resp_base[0], 8'h20);
        tick();
        do_req(0, 1'b0, 8'h20, 8'h04, 8'h00, 1'b1);
        check("pi_mem_ea",      mem_ea[0],    8'h20);
        tick();
        check("pi_resp_ea",     resp_ea[0],   8'h20);
        check("pi_resp_rdata",  resp_rdata[0], 8'h77);
        check("pi_resp_base",   resp_base[0], 8'h24);
        tick();
        $display("[TB] inst0 postinc load done");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lsu_access_ctrl.md
# lsu_access_ctrl

Load/store access controller sitting directly upstream of the 8-bit data memory. Accepts one load or store request at a time from the execute stage over a valid/ready handshake and computes the 8-bit effective address. Drives the memory's address, write-data and write-enable lines for exactly one access, then returns load data (or store completion) over a valid/ready response handshake. Memory has 256 bytes, a combinational read and a write on the falling clock edge.

## Interface
- `WAIT_STATES`, default 0: extra ACCESS cycles before completion. Legal range is 0–15; 4-bit counter.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_store`  in  1  1 = store, 0 = load.
- `req_base`  in  8  base address.
- `req_offset`  in  8  address offset; added modulo 256.
- `req_wdata`  in  8  store data.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer accepts response.
- `resp_rdata`  out  8  load data; 0 for stores.
- `resp_ea`  out  8  effective address used.
- `mem_ea`  out  8  memory address, connects to memory `ea`.
- `mem_result`  out  8  memory write data, connects to memory `result`.
- `mem_en`  out  1  memory write enable.
- `mem_data`  in  8  memory combinational read data.

## Operation
- **States:** IDLE, ACCESS, RESP. Reset state is IDLE.
- **IDLE:**
  - `req_ready`=1.
  - On `req_valid`&&`req_ready`, latch the request:
    - op_q ← `req_store`
    - ea_q ← (`req_base`+`req_offset`)[7:0]
    - wdata_q ← `req_wdata`
    - cnt ← `WAIT_STATES`
  - Then go to ACCESS.
- **ACCESS:**
  - `mem_ea`=ea_q and `mem_result`=wdata_q, held stable for the whole state.
  - If cnt≠0: decrement cnt.
  - If cnt==0:
    - For a load, rdata_q ← `mem_data`.
    - For a store, rdata_q ← 0.
    - Go to RESP.
- **`mem_en`:** equals (state==ACCESS && op_q && cnt==0). It is decoded only from registered state. Exactly one write-enable cycle per store; 0 for loads.
- **RESP:**
  - `resp_valid`=1, with `resp_rdata`=rdata_q and `resp_ea`=ea_q.
  - On `resp_ready`, go to IDLE.
  - Response fields stay stable while `resp_valid`=1 and `resp_ready`=0.
- **No bypass:** `req_ready`=0 in ACCESS and RESP. A request offered then is ignored and must be held by the producer.
- **Address wrap:** the carry out of the address add is discarded, e.g. 0xF0+0x20 → 0x10.
- **Outputs outside ACCESS:** `mem_ea` and `mem_result` keep their last latched values; only `mem_en` gates writes.
- **Reset values:** `req_ready`=1 after the reset edge (IDLE). All of these are 0:
  - `resp_valid`, `resp_rdata`, `resp_ea`
  - `mem_ea`, `mem_result`, `mem_en`
  - ea_q, wdata_q, rdata_q, cnt
- **Reset mid-operation:**
  - `rst` sampled high in any state forces IDLE at that edge; the in-flight request is dropped with no response.
  - A store whose write cycle coincides with `rst` high is not guaranteed committed; the shared `rst` clears the memory anyway.

## Timing
- Request handshake at rising edge T0 → ACCESS occupies cycles T0..T0+`WAIT_STATES`.
- Store write happens on the falling edge inside the final ACCESS cycle.
- Load data is sampled at rising edge T0+`WAIT_STATES`+1.
- `resp_valid` rises after edge T0+`WAIT_STATES`+1; latency is `WAIT_STATES`+1 cycles.
- If `resp_ready`=1, RESP lasts one cycle; `req_ready` returns after edge T0+`WAIT_STATES`+2.
- Peak throughput is one access per `WAIT_STATES`+3 cycles.
- `mem_ea` changes only on the rising edge entering ACCESS, so it is stable across the write falling edge.

## Configuration
- **`LSU_POSTINC_EN` defined:**
  - Adds input `req_postinc` (1 bit) and output `resp_base` (8 bits, reset 0).
  - With `req_postinc`=1: ea_q ← `req_base`, and `resp_base` ← (`req_base`+`req_offset`)[7:0] for base-register writeback.
  - With `req_postinc`=0: ea_q ← (`req_base`+`req_offset`)[7:0], and `resp_base` ← `req_base`.
  - `resp_base` is valid with `resp_valid`.
- **`LSU_POSTINC_EN` undefined:** both ports are absent and ea is always base+offset.

## Test plan
- **Store then load, W=0:**
  - Store base=0x10, offset=0x05, wdata=0xA5 → `mem_en`=1 for exactly one cycle with `mem_ea`=0x15; response has `resp_ea`=0x15 and `resp_rdata`=0.
  - Load 0x10+0x05 → `resp_rdata`=0xA5, with `resp_valid` one cycle after acceptance.
- **Wrap:** store base=0xF0, offset=0x20, data 0x3C → memory[0x10]=0x3C, `resp_ea`=0x10.
- **Wait states:** `WAIT_STATES`=3, load → `resp_valid` 4 cycles after acceptance; for a store, `mem_en` is high only in the 4th ACCESS cycle.
- **Backpressure:**
  - Hold `resp_ready`=0 for 5 cycles → `resp_valid`, `resp_rdata` and `resp_ea` stay stable and `req_ready`=0.
  - A second `req_valid` offered meanwhile is not accepted until one cycle after the response handshake.
- **Reset mid-op:** assert `rst` during ACCESS of a load → next cycle IDLE, `req_ready`=1, `resp_valid`=0, and all outputs at their reset values.
- **`LSU_POSTINC_EN`:** load base=0x20, offset=0x04, postinc=1 with memory[0x20]=0x77 → `resp_ea`=0x20, `resp_rdata`=0x77, `resp_base`=0x24.
